mult_share_arbiter: RTL and testbench

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

---
 rtl/mult_share_pkg.sv | 8 +
 rtl/mult_share_arbiter_mult.sv | 47 ++++
 rtl/mult_share_arbiter.sv | 117 +++++++++++
 tb/tb_mult_share_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// rtl/mult_share_pkg.sv - shared constants for the multiplier-sharing arbiter
package mult_share_pkg;
    localparam int NUM_REQ    = 4;
    localparam int A_WIDTH    = 9;
    localparam int B_WIDTH    = 9;
    localparam int ID_WIDTH   = $clog2(NUM_REQ);
    localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/mult_share_arbiter_mult.sv
// rtl/mult_share_arbiter_mult.sv - registered signed/unsigned multiplier with split half mode
module mult_share_arbiter_mult #(
    parameter int A_WIDTH = mult_share_pkg::A_WIDTH,
    parameter int B_WIDTH = mult_share_pkg::B_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    input  logic                       a_sign,
    input  logic                       b_sign,
    input  logic                       half,
    output logic [A_WIDTH+B_WIDTH-1:0] product
);
    import mult_share_pkg::*;

    localparam int P_W  = A_WIDTH + B_WIDTH;
    localparam int LA   = A_WIDTH / 2;
    localparam int LB   = B_WIDTH / 2;
    localparam int HA   = A_WIDTH - LA;
    localparam int HB   = B_WIDTH - LB;

    logic [P_W-1:0]     a_ext;
    logic [P_W-1:0]     b_ext;
    logic [P_W-1:0]     full_prod;
    logic [LA+LB-1:0]   lo_prod;
    logic [HA+HB-1:0]   hi_prod;
    logic [P_W-1:0]     product_d;

    // Modular product of the extended operands equals the truncated signed product.
    always_comb begin
        a_ext     = {{B_WIDTH{a_sign & a[A_WIDTH-1]}}, a};
        b_ext     = {{A_WIDTH{b_sign & b[B_WIDTH-1]}}, b};
        full_prod = a_ext * b_ext;
        lo_prod   = {{LB{1'b0}}, a[LA-1:0]} * {{LA{1'b0}}, b[LB-1:0]};
        hi_prod   = {{HB{1'b0}}, a[A_WIDTH-1:LA]} * {{HA{1'b0}}, b[B_WIDTH-1:LB]};
        product_d = half ? {hi_prod, lo_prod} : full_prod;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            product <= '0;
        end else begin
            product <= product_d;
        end
    end
endmodule

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sharing of one registered multiplier with a 2-entry result FIFO
module mult_share_arbiter #(
    parameter int NUM_REQ = mult_share_pkg::NUM_REQ,
    parameter int A_WIDTH = mult_share_pkg::A_WIDTH,
    parameter int B_WIDTH = mult_share_pkg::B_WIDTH,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_A,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_B,
    input  logic [NUM_REQ-1:0]           req_A_sign,
    input  logic [NUM_REQ-1:0]           req_B_sign,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [A_WIDTH+B_WIDTH-1:0]   out_data,
    output logic [ID_W-1:0]              out_id,
    output logic                         busy
);
    import mult_share_pkg::*;

    localparam int P_W = A_WIDTH + B_WIDTH;

    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    issued_id;
    logic               inflight;
    logic [1:0]         count;
    logic               wr_ptr;
    logic               rd_ptr;
    logic [P_W-1:0]     mem_data [FIFO_DEPTH];
    logic [ID_W-1:0]    mem_id   [FIFO_DEPTH];
    logic [2:0]         pending;
    logic               credit;
    logic               issue;
    logic               pop;
    logic [P_W-1:0]     product;
    logic [A_WIDTH-1:0] a_sel;
    logic [B_WIDTH-1:0] b_sel;
    int                 idx;
    logic               found;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    // Results already committed (FIFO + in flight) net of this cycle's pop must fit the FIFO.
    assign pop       = out_valid & out_ready;
    assign pending   = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign credit    = pending < 3'(FIFO_DEPTH);
    assign issue     = (|req_valid) & credit;
    assign req_ready = issue ? (NUM_REQ'(1) << winner) : '0;

    assign a_sel = req_A[int'(winner)*A_WIDTH +: A_WIDTH];
    assign b_sel = req_B[int'(winner)*B_WIDTH +: B_WIDTH];

    mult_share_arbiter_mult #(
        .A_WIDTH (A_WIDTH),
        .B_WIDTH (B_WIDTH)
    ) u_mult (
        .clk     (clk),
        .rst     (~reset),
        .a       (a_sel),
        .b       (b_sel),
        .a_sign  (req_A_sign[winner]),
        .b_sign  (req_B_sign[winner]),
        .half    (1'b0),
        .product (product)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight   <= 1'b0;
            issued_id  <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_id[i]   <= '0;
            end
        end else begin
            inflight <= issue;
            if (issue) begin
                issued_id  <= winner;
                last_grant <= winner;
            end
            if (inflight) begin
                mem_data[wr_ptr] <= product;
                mem_id[wr_ptr]   <= issued_id;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

    assign out_valid = (count != 2'd0);
    assign out_data  = mem_data[rd_ptr];
    assign out_id    = mem_id[rd_ptr];
    assign busy      = inflight | (count != 2'd0);
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - self-checking bench for mult_share_arbiter
module tb_mult_share_arbiter;
    import mult_share_pkg::*;

    localparam int N  = NUM_REQ;
    localparam int AW = A_WIDTH;
    localparam int BW = B_WIDTH;
    localparam int PW = AW + BW;
    localparam int IW = ID_WIDTH;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_A = '0;
    logic [N*BW-1:0]   req_B = '0;
    logic [N-1:0]      req_A_sign = '0;
    logic [N-1:0]      req_B_sign = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [PW-1:0]     out_data;
    logic [IW-1:0]     out_id;
    logic              busy;

    mult_share_arbiter #(.NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_A      (req_A),
        .req_B      (req_B),
        .req_A_sign (req_A_sign),
        .req_B_sign (req_B_sign),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] data;
        int            id;
        int            cyc;
    } res_t;

    res_t          q[$];
    int            last_g;
    int            now_c;
    int            tests_run = 0;
    int            tests_failed = 0;
    logic [N-1:0]  exp_ready;
    logic          exp_valid;
    logic          exp_busy;
    logic          exp_issue;
    logic          exp_pop;
    logic [PW-1:0] exp_data;
    int            exp_id;
    int            exp_win;

    function automatic logic [PW-1:0] ref_mul(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                             input logic as, input logic bs);
        longint av, bv, p;
        logic [63:0] t;
        av = longint'(a);
        bv = longint'(b);
        if (as && a[AW-1]) av = av - (longint'(1) << AW);
        if (bs && b[BW-1]) bv = bv - (longint'(1) << BW);
        p = av * bv;
        t = p;
        return t[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] req_product(input int i);
        return ref_mul(req_A[i*AW +: AW], req_B[i*BW +: BW], req_A_sign[i], req_B_sign[i]);
    endfunction

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b,
                           input logic as, input logic bs);
        req_A[i*AW +: AW] = a;
        req_B[i*BW +: BW] = b;
        req_A_sign[i]     = as;
        req_B_sign[i]     = bs;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req_valid = '0;
        out_ready = 1'b0;
        reset     = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Reference: every accepted request is a queue entry visible at the head two cycles later.
    task automatic model_reset();
        q.delete();
        last_g = N - 1;
        now_c  = 0;
    endtask

    task automatic model_predict();
        exp_valid = (q.size() > 0) && (q[0].cyc <= now_c - 2);
        exp_data  = exp_valid ? q[0].data : '0;
        exp_id    = exp_valid ? q[0].id : 0;
        exp_pop   = exp_valid && out_ready;
        exp_busy  = q.size() > 0;
        exp_win   = -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last_g + k) % N;
            if (exp_win < 0 && req_valid[i]) exp_win = i;
        end
        exp_issue = (exp_win >= 0) && ((q.size() - (exp_pop ? 1 : 0)) < 2);
        exp_ready = '0;
        if (exp_issue) exp_ready[exp_win] = 1'b1;
    endtask

    task automatic model_commit();
        res_t r;
        if (exp_pop) void'(q.pop_front());
        if (exp_issue) begin
            r.data = req_product(exp_win);
            r.id   = exp_win;
            r.cyc  = now_c;
            q.push_back(r);
            last_g = exp_win;
        end
        now_c++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: out_valid=%b busy=%b expected 0 0", out_valid, busy);
        end
        tests_run++;
        if (out_data !== '0 || out_id !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: data=%h id=%0d expected 0 0", out_data, out_id);
        end
        tick();
        tick();
        reset = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== '0) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b expected 0", req_ready);
        end
    endtask

    task automatic test_products();
        logic [AW-1:0] ta [3];
        logic [BW-1:0] tb [3];
        logic          tas [3];
        logic          tbs [3];
        logic [PW-1:0] texp [3];
        ta = '{9'h100, 9'h1FF, 9'h1FF};
        tb = '{9'h100, 9'h1FF, 9'h1FF};
        tas = '{1'b1, 1'b0, 1'b1};
        tbs = '{1'b1, 1'b0, 1'b0};
        texp = '{18'h10000, 18'h3FC01, 18'h3FE01};
        do_reset();
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            set_req(j, ta[j], tb[j], tas[j], tbs[j]);
            req_valid = N'(1) << j;
            #1;
            tests_run++;
            if (req_ready !== (N'(1) << j)) begin
                tests_failed++;
                $display("FAIL prod_ready[%0d]: got %b expected %b", j, req_ready, N'(1) << j);
            end
            tick();
            req_valid = '0;
            #1;
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL prod_early[%0d]: out_valid=%b expected 0", j, out_valid);
            end
            tick();
            #1;
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== texp[j] || out_id !== IW'(j)) begin
                tests_failed++;
                $display("FAIL prod_result[%0d]: valid=%b data=%h id=%0d expected 1 %h %0d",
                         j, out_valid, out_data, out_id, texp[j], j);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++)
            set_req(i, AW'($urandom), BW'($urandom), 1'($urandom), 1'($urandom));
        out_ready = 1'b1;
        req_valid = '1;
        for (int c = 0; c < 16; c++) begin
            #1;
            tests_run++;
            if (req_ready !== (N'(1) << (c % N))) begin
                tests_failed++;
                $display("FAIL rr_grant c=%0d: got %b expected %b", c, req_ready, N'(1) << (c % N));
            end
            tests_run++;
            if (c < 2) begin
                if (out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rr_latency c=%0d: out_valid=%b expected 0", c, out_valid);
                end
            end else if (out_valid !== 1'b1 || out_id !== IW'((c - 2) % N)
                         || out_data !== req_product((c - 2) % N)) begin
                tests_failed++;
                $display("FAIL rr_out c=%0d: valid=%b id=%0d data=%h expected 1 %0d %h", c,
                         out_valid, out_id, out_data, (c - 2) % N, req_product((c - 2) % N));
            end
            tick();
        end
        req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_stall();
        logic [N-1:0] er;
        do_reset();
        for (int i = 0; i < N; i++)
            set_req(i, AW'($urandom), BW'($urandom), 1'($urandom), 1'($urandom));
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            er = (c < 2) ? (N'(1) << c) : '0;
            #1;
            tests_run++;
            if (req_ready !== er) begin
                tests_failed++;
                $display("FAIL stall_ready c=%0d: got %b expected %b", c, req_ready, er);
            end
            if (c >= 2) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_id !== '0 || out_data !== req_product(0) || busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL stall_hold c=%0d: valid=%b id=%0d data=%h busy=%b expected 1 0 %h 1",
                             c, out_valid, out_id, out_data, busy, req_product(0));
                end
            end
            tick();
        end
        req_valid = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            tests_run++;
            if (k < 2) begin
                if (out_valid !== 1'b1 || out_id !== IW'(k) || out_data !== req_product(k)) begin
                    tests_failed++;
                    $display("FAIL drain k=%0d: valid=%b id=%0d data=%h expected 1 %0d %h",
                             k, out_valid, out_id, out_data, k, req_product(k));
                end
            end else if (out_valid !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL drain_empty k=%0d: valid=%b busy=%b expected 0 0", k, out_valid, busy);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 9'h003, 9'h005, 1'b0, 1'b0);
        req_valid = '1;
        tick();
        tick();
        #1;
        tests_run++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_pre: busy=%b valid=%b expected 1 1", busy, out_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || out_id !== '0) begin
            tests_failed++;
            $display("FAIL mid_async: valid=%b busy=%b data=%h id=%0d expected 0 0 0 0",
                     out_valid, busy, out_data, out_id);
        end
        @(negedge clk);
        reset = 1'b1;
        set_req(0, 9'h07B, 9'h011, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++;
            if (c == 0) begin
                if (req_ready !== N'(1)) begin
                    tests_failed++;
                    $display("FAIL mid_first_grant: got %b expected %b", req_ready, N'(1));
                end
            end else if (c == 1) begin
                if (out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL mid_stale: out_valid=%b expected 0", out_valid);
                end
            end else if (out_valid !== 1'b1 || out_id !== '0 || out_data !== 18'h082B) begin
                tests_failed++;
                $display("FAIL mid_new: valid=%b id=%0d data=%h expected 1 0 0082b",
                         out_valid, out_id, out_data);
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++)
                set_req(i, AW'($urandom), BW'($urandom), 1'($urandom), 1'($urandom));
            out_ready = (c % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            #1;
            model_predict();
            tests_run++;
            if (req_ready !== exp_ready) begin
                tests_failed++;
                $display("FAIL rnd_ready c=%0d: got %b expected %b", c, req_ready, exp_ready);
            end
            tests_run++;
            if (out_valid !== exp_valid || busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL rnd_flags c=%0d: valid=%b busy=%b expected %b %b",
                         c, out_valid, busy, exp_valid, exp_busy);
            end
            if (exp_valid) begin
                tests_run++;
                if (out_data !== exp_data || out_id !== IW'(exp_id)) begin
                    tests_failed++;
                    $display("FAIL rnd_result c=%0d: data=%h id=%0d expected %h %0d",
                             c, out_data, out_id, exp_data, exp_id);
                end
            end
            model_commit();
            tick();
        end
        req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        test_reset();
        @(negedge clk);
        test_products();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
